// File: rtl/ddr_arb_pkg.sv
// Shared types and default widths for the two-port DDR Avalon arbiter.
package ddr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    WBURST = 2'd2
  } arb_state_e;

  typedef logic req_id_t;

  localparam int DEF_ADDR_W   = 25;
  localparam int DEF_DATA_W   = 256;
  localparam int DEF_BURST_W  = 7;
  localparam int DEF_RD_DEPTH = 8;

  // Round-robin pick: the pointer only matters when both requesters compete.
  function automatic req_id_t rr_pick(input logic elig0, input logic elig1,
                                      input logic ptr);
    req_id_t win;
    if (elig0 && elig1) win = req_id_t'(ptr);
    else if (elig1)     win = req_id_t'(1'b1);
    else                win = req_id_t'(1'b0);
    return win;
  endfunction

endpackage

// File: rtl/ddr_arb_id_fifo.sv
// Ordered record of outstanding reads: {requester id, burstcount} per entry.
module ddr_arb_id_fifo
  import ddr_arb_pkg::*;
#(
  parameter int BURST_W  = DEF_BURST_W,
  parameter int RD_DEPTH = DEF_RD_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  req_id_t            push_id,
  input  logic [BURST_W-1:0] push_bc,
  input  logic               pop,
  output req_id_t            head_id,
  output logic [BURST_W-1:0] head_bc,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(RD_DEPTH);

  req_id_t            id_mem_q [RD_DEPTH];
  logic [BURST_W-1:0] bc_mem_q [RD_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic               push_ok, pop_ok;

  assign full    = (cnt_q == (AW+1)'(RD_DEPTH));
  assign empty   = (cnt_q == '0);
  assign head_id = id_mem_q[rd_ptr_q];
  assign head_bc = bc_mem_q[rd_ptr_q];

  // When full, a simultaneous pop frees the slot the push lands in.
  always_comb begin
    push_ok  = push && (!full || pop);
    pop_ok   = pop && !empty;
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok && !pop_ok)      cnt_d = cnt_q + (AW+1)'(1);
    else if (!push_ok && pop_ok) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      id_mem_q[wr_ptr_q] <= push_id;
      bc_mem_q[wr_ptr_q] <= push_bc;
    end
  end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Two-requester Avalon-MM arbiter in front of a DDR controller port:
// round-robin grants, write bursts held to completion, reads tracked in order.
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int BURST_W  = DEF_BURST_W,
  parameter int RD_DEPTH = DEF_RD_DEPTH
) (
  input  logic                avalon_clk,
  input  logic                avalon_reset,

  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [BURST_W-1:0]  m0_burstcount,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,

  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [BURST_W-1:0]  m1_burstcount,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,

  output logic [ADDR_W-1:0]   amm_addr,
  output logic                amm_read,
  output logic                amm_write,
  output logic [DATA_W-1:0]   amm_writedata,
  output logic [DATA_W/8-1:0] amm_byteenable,
  output logic [BURST_W-1:0]  amm_burstcount,
  input  logic [DATA_W-1:0]   amm_readdata,
  input  logic                amm_readdatavalid,
  input  logic                amm_waitrequest,

  output logic                busy
);

  arb_state_e         state_q, state_d;
  req_id_t            grant_q, grant_d;
  logic               ptr_q, ptr_d;
  logic [BURST_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [BURST_W-1:0] ret_cnt_q, ret_cnt_d;
  logic               rd_err_q, rd_err_d;

  logic               g_read, g_write;
  logic [BURST_W-1:0] g_bc;
  logic               elig0, elig1;
  logic               gnt_wait;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  req_id_t            head_id;
  logic [BURST_W-1:0] head_bc;
  logic               rd_hit, ret_last;

  ddr_arb_id_fifo #(
    .BURST_W  (BURST_W),
    .RD_DEPTH (RD_DEPTH)
  ) u_id_fifo (
    .clk     (avalon_clk),
    .rst     (avalon_reset),
    .push    (fifo_push),
    .push_id (grant_q),
    .push_bc (g_bc),
    .pop     (fifo_pop),
    .head_id (head_id),
    .head_bc (head_bc),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign g_read         = grant_q ? m1_read       : m0_read;
  assign g_write        = grant_q ? m1_write      : m0_write;
  assign g_bc           = grant_q ? m1_burstcount : m0_burstcount;
  assign amm_addr       = grant_q ? m1_addr       : m0_addr;
  assign amm_writedata  = grant_q ? m1_writedata  : m0_writedata;
  assign amm_byteenable = grant_q ? m1_byteenable : m0_byteenable;
  assign amm_burstcount = g_bc;

  // A zero burstcount is not a command, and a read needs a free tracking slot.
  assign elig0 = (m0_write || (m0_read && !fifo_full)) && (m0_burstcount != '0);
  assign elig1 = (m1_write || (m1_read && !fifo_full)) && (m1_burstcount != '0);

  assign busy = (state_q != IDLE) || !fifo_empty;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    fifo_push  = 1'b0;
    amm_read   = 1'b0;
    amm_write  = 1'b0;
    gnt_wait   = 1'b1;

    case (state_q)
      IDLE: begin
        if (elig0 || elig1) begin
          grant_d = rr_pick(elig0, elig1, ptr_q);
          state_d = CMD;
        end
      end
      CMD: begin
        gnt_wait  = amm_waitrequest;
        amm_write = g_write;
        amm_read  = g_read && !g_write;
        if (g_write) begin
          if (!amm_waitrequest) begin
            if (g_bc == BURST_W'(1)) begin
              state_d = IDLE;
              ptr_d   = !ptr_q;
            end else begin
              beat_cnt_d = g_bc - BURST_W'(1);
              state_d    = WBURST;
            end
          end
        end else if (g_read) begin
          if (!amm_waitrequest) begin
            fifo_push = 1'b1;
            state_d   = IDLE;
            ptr_d     = !ptr_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WBURST: begin
        gnt_wait  = amm_waitrequest;
        amm_write = g_write;
        if (g_write && !amm_waitrequest) begin
          beat_cnt_d = beat_cnt_q - BURST_W'(1);
          if (beat_cnt_q == BURST_W'(1)) begin
            state_d = IDLE;
            ptr_d   = !ptr_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (avalon_reset) begin
      amm_read  = 1'b0;
      amm_write = 1'b0;
      fifo_push = 1'b0;
      gnt_wait  = 1'b1;
    end
  end

  assign m0_waitrequest = (grant_q == 1'b0) ? gnt_wait : 1'b1;
  assign m1_waitrequest = (grant_q == 1'b1) ? gnt_wait : 1'b1;

  // Return path: beats belong to the oldest outstanding read, steered with no delay.
  always_comb begin
    rd_hit    = amm_readdatavalid && !fifo_empty && !avalon_reset;
    ret_last  = rd_hit && ((ret_cnt_q + BURST_W'(1)) == head_bc);
    fifo_pop  = ret_last;
    ret_cnt_d = ret_cnt_q;
    if (rd_hit) ret_cnt_d = ret_last ? '0 : ret_cnt_q + BURST_W'(1);
    rd_err_d  = rd_err_q || (amm_readdatavalid && fifo_empty);
  end

  assign m0_readdatavalid = rd_hit && (head_id == 1'b0);
  assign m1_readdatavalid = rd_hit && (head_id == 1'b1);
  assign m0_readdata      = amm_readdata;
  assign m1_readdata      = amm_readdata;

  always_ff @(posedge avalon_clk) begin
    if (avalon_reset) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      ptr_q      <= 1'b0;
      beat_cnt_q <= '0;
      ret_cnt_q  <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
      ret_cnt_q  <= ret_cnt_d;
      rd_err_q   <= rd_err_d;
    end
  end

endmodule

// File: doc/ddr_port_arbiter.md
DDR_PORT_ARBITER -- requirements
Module: ddr_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, DDR word address width.
REQ-002 SHALL have parameter DATA_W, default 256, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have parameter BURST_W, default 7, burstcount width.
REQ-004 SHALL have parameter RD_DEPTH, default 8, maximum outstanding read commands (power of 2).
REQ-005 SHALL use a single clock and a synchronous, active-high reset:
  avalon_clk  in  1  single clock for all logic
  avalon_reset  in  1  synchronous active-high reset
REQ-006 SHALL have two requester ports, N=0,1, with these signals:
  mN_addr  in  ADDR_W  address
  mN_read / mN_write  in  1  command strobes
  mN_writedata  in  DATA_W  write data
  mN_byteenable  in  DATA_W/8  byte enables
  mN_burstcount  in  BURST_W  burst length, 1..64
  mN_waitrequest  out  1  stall
  mN_readdata  out  DATA_W  read data
  mN_readdatavalid  out  1  read beat valid
REQ-007 SHALL have a DDR master port carrying amm_addr, amm_read, amm_write, amm_writedata, amm_byteenable and amm_burstcount (all out), amm_readdata and amm_readdatavalid (in), and amm_waitrequest (in, 1 = stall).
REQ-008 SHALL have output busy, 1 while any grant is held or any read is outstanding.

Function
REQ-009 SHALL implement an FSM with states IDLE, CMD and WBURST.
REQ-010 IDLE: requester N is eligible when mN_write=1, or when mN_read=1 and the ID FIFO is not full; on a registered winner the FSM moves to CMD the next cycle; arbitration latency is 1 cycle.
REQ-011 SHALL resolve contention round-robin: a priority pointer, reset to 0, toggles after each completed transaction; with one eligible requester, that requester wins regardless of the pointer.
REQ-012 CMD/WBURST: amm_* outputs SHALL mux the granted requester's signals; the granted mN_waitrequest equals amm_waitrequest; the non-granted requester sees waitrequest=1.
REQ-013 In IDLE, both mN_waitrequest SHALL be 1 and amm_read=amm_write=0.
REQ-014 CMD, write accepted (amm_waitrequest=0): if burstcount=1, go to IDLE; else load beat counter = burstcount-1 and go to WBURST.
REQ-015 WBURST: each accepted beat decrements the counter; on the accepted beat with counter=1, go to IDLE; the grant is never revoked mid-burst.
REQ-016 CMD, read accepted: push {id, burstcount} into the ID FIFO, then go to IDLE.
REQ-017 Read return: amm_readdatavalid beats SHALL route to the FIFO-head id with zero latency (combinational); readdata goes to both ports and only readdatavalid is steered.
REQ-018 SHALL pop the FIFO head when its returned-beat count reaches its burstcount; a push and a pop in the same cycle are legal at any level, including full.
REQ-019 amm_readdatavalid with the ID FIFO empty is a protocol error: the beat SHALL be dropped and a sticky internal flag set, readable in simulation.
REQ-020 SHALL ignore a burstcount of 0 as a command: the requester is stalled, with no grant issued.
REQ-021 busy SHALL equal (state!=IDLE) or (FIFO not empty).

Reset
REQ-022 avalon_reset SHALL force: state IDLE, pointer 0, beat and return counters 0, ID FIFO empty, error flag 0.
REQ-023 While in reset, all mN_waitrequest SHALL be 1, and amm_read, amm_write and mN_readdatavalid SHALL be 0.
REQ-024 Reset mid-burst or with reads outstanding SHALL abandon state with no completion; the system resets the DDR side together with this block.

Structure
REQ-025 Package ddr_arb_pkg SHALL hold the FSM state enum, the requester-id type and the default widths.
REQ-026 SHALL have one sub-module, ddr_arb_id_fifo: a synchronous FIFO of {id, burstcount} entries, RD_DEPTH deep, with full/empty flags and same-cycle push/pop.

Verification
REQ-027 m0 writes burst 4 at 0x100 while m1 writes burst 2 one cycle later -> m0 gets 4 beats contiguously, then m1 gets 2; m1_waitrequest=1 throughout m0's burst.
REQ-028 Both requesters read burst 1 every cycle -> grants alternate 0,1,0,1; readdatavalid is steered in issue order.
REQ-029 m0 issues 8 reads of burst 2 with DDR returns withheld -> the 9th m0 read stalls (FIFO full); after 2 return beats, a read is granted in the same or next cycle.
REQ-030 amm_waitrequest=1 for 5 cycles in WBURST with counter=2 -> counter holds at 2; the burst completes after 2 accepted beats.
REQ-031 avalon_reset asserted in WBURST with counter=3 -> next cycle: IDLE, busy=0, both waitrequest=1, no amm_write.
REQ-032 Spurious amm_readdatavalid with the FIFO empty -> no mN_readdatavalid pulse; error flag=1.
